// File: rtl/pio_pkg.sv
// Shared constants for the pio_hs_n parallel I/O block: register offsets,
// CTRL/STATUS bit positions and mode encodings.
package pio_pkg;

  localparam logic [2:0] REG_DATA  = 3'd0;
  localparam logic [2:0] REG_DIR   = 3'd1;
  localparam logic [2:0] REG_CTRL  = 3'd2;
  localparam logic [2:0] REG_STAT  = 3'd3;
  localparam logic [2:0] REG_IMASK = 3'd4;
  localparam logic [2:0] REG_IPEND = 3'd5;

  localparam int CTRL_MODE  = 0;
  localparam int CTRL_HSDIR = 1;
  localparam int CTRL_INTE  = 2;

  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_OBF    = 3;
  localparam int ST_INTR   = 4;

  localparam logic MODE_SIMPLE = 1'b0;
  localparam logic MODE_HS     = 1'b1;
  localparam logic HSDIR_IN    = 1'b0;
  localparam logic HSDIR_OUT   = 1'b1;

endpackage

// File: rtl/pio_port.sv
// One PIO port: OUT/DIR/CTRL registers, pad/strobe/ack synchronisers,
// input capture FIFO and OBF/ACK output handshake.
// Optional per-bit change interrupts when PIO_EDGE_IRQ_EN is defined.
module pio_port
  import pio_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [2:0]       reg_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] pin_o,
  output logic [WIDTH-1:0] pin_oe,
  input  logic             stb_ni,
  input  logic             ack_ni,
  output logic             obf_no,
  output logic             intr_o
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [WIDTH-1:0] out_q, dir_q;
  logic [2:0]       ctrl_q;
  logic [WIDTH-1:0] pin_s1_q, pin_s2_q;
  logic [1:0]       hs_s1_q, hs_s2_q, hs_edge_q;   // bit0 strobe, bit1 ack
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTRW-1:0]  wptr_q, rptr_q;
  logic [CNTW-1:0]  cnt_q;
  logic             ovf_q, obf_q, hs_intr_q;
  logic             edge_irq;

  logic hs_in, hs_out, inte, nempty, full;
  logic wr_data, wr_dir, wr_ctrl, wr_stat, mode_chg;
  logic stb_fall, ack_fall, ack_rise, push_req, push, pop;

  assign hs_in    = (ctrl_q[CTRL_MODE] == MODE_HS) && (ctrl_q[CTRL_HSDIR] == HSDIR_IN);
  assign hs_out   = (ctrl_q[CTRL_MODE] == MODE_HS) && (ctrl_q[CTRL_HSDIR] == HSDIR_OUT);
  assign inte     = ctrl_q[CTRL_INTE];
  assign nempty   = (cnt_q != '0);
  assign full     = (cnt_q == CNTW'(FIFO_DEPTH));

  assign wr_data  = wr_i && (reg_i == REG_DATA);
  assign wr_dir   = wr_i && (reg_i == REG_DIR);
  assign wr_ctrl  = wr_i && (reg_i == REG_CTRL);
  assign wr_stat  = wr_i && (reg_i == REG_STAT);
  assign mode_chg = wr_ctrl &&
                    ({wdata_i[CTRL_HSDIR], wdata_i[CTRL_MODE]} != {ctrl_q[CTRL_HSDIR], ctrl_q[CTRL_MODE]});

  assign stb_fall = hs_edge_q[0] & ~hs_s2_q[0];
  assign ack_fall = hs_edge_q[1] & ~hs_s2_q[1];
  assign ack_rise = ~hs_edge_q[1] & hs_s2_q[1];

  // A pop on an empty FIFO is a no-op; a pop frees room for a same-cycle push.
  assign pop      = rd_i && (reg_i == REG_DATA) && hs_in && nempty;
  assign push_req = hs_in && stb_fall;
  assign push     = push_req && (!full || pop);

  // Two-flop synchronisers plus edge-detect stage; strobe/ack idle high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pin_s1_q  <= '0;
      pin_s2_q  <= '0;
      hs_s1_q   <= 2'b11;
      hs_s2_q   <= 2'b11;
      hs_edge_q <= 2'b11;
    end else begin
      pin_s1_q  <= pin_i;
      pin_s2_q  <= pin_s1_q;
      hs_s1_q   <= {ack_ni, stb_ni};
      hs_s2_q   <= hs_s1_q;
      hs_edge_q <= hs_s2_q;
    end
  end

  // Configuration registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q  <= '0;
      dir_q  <= '0;
      ctrl_q <= '0;
    end else begin
      if (wr_data) out_q  <= wdata_i;
      if (wr_dir)  dir_q  <= wdata_i;
      if (wr_ctrl) ctrl_q <= wdata_i[2:0];
    end
  end

  // FIFO storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (push && !mode_chg) mem_q[wptr_q] <= pin_s2_q;
  end

  // FIFO pointers, count and sticky overflow; a mode change flushes everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (mode_chg) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTRW'(1);
      if (pop)  rptr_q <= rptr_q + PTRW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CNTW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNTW'(1);
      if (push_req && !push)                 ovf_q <= 1'b1;
      else if (wr_stat && wdata_i[ST_OVF])   ovf_q <= 1'b0;
    end
  end

  // Output handshake: a DATA write beats a coincident ack fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      obf_q     <= 1'b0;
      hs_intr_q <= 1'b0;
    end else if (mode_chg) begin
      obf_q     <= 1'b0;
      hs_intr_q <= 1'b0;
    end else begin
      if (hs_out && wr_data)       obf_q <= 1'b1;
      else if (hs_out && ack_fall) obf_q <= 1'b0;
      if (hs_out && wr_data)                hs_intr_q <= 1'b0;
      else if (hs_out && ack_rise && inte)  hs_intr_q <= 1'b1;
      else if (wr_stat && wdata_i[ST_INTR]) hs_intr_q <= 1'b0;
    end
  end

`ifdef PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] imask_q, ipend_q, ipend_d, pin_edge_q;

  // Change detection on synced input bits, W1C pending register.
  always_comb begin
    ipend_d = ipend_q;
    if (wr_i && (reg_i == REG_IPEND)) ipend_d = ipend_d & ~wdata_i;
    if (ctrl_q[CTRL_MODE] == MODE_SIMPLE) ipend_d = ipend_d | ((pin_s2_q ^ pin_edge_q) & ~dir_q);
    if (mode_chg) ipend_d = '0;
  end

  // Edge-detect stage for pins plus mask/pending registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pin_edge_q <= '0;
      imask_q    <= '0;
      ipend_q    <= '0;
    end else begin
      pin_edge_q <= pin_s2_q;
      ipend_q    <= ipend_d;
      if (wr_i && (reg_i == REG_IMASK)) imask_q <= wdata_i;
    end
  end

  assign edge_irq = |(ipend_q & imask_q);
`else
  assign edge_irq = 1'b0;
`endif

  assign intr_o = (hs_in && inte && nempty) || (hs_out && hs_intr_q) || edge_irq;
  assign obf_no = ~obf_q;
  assign pin_o  = out_q;
  assign pin_oe = hs_in ? '0 : (hs_out ? '1 : dir_q);

  // Register read mux.
  always_comb begin
    rdata_o = '0;
    case (reg_i)
      REG_DATA: begin
        if (hs_in)       rdata_o = nempty ? mem_q[rptr_q] : '0;
        else if (hs_out) rdata_o = out_q;
        else             rdata_o = (dir_q & out_q) | (~dir_q & pin_s2_q);
      end
      REG_DIR:  rdata_o = dir_q;
      REG_CTRL: rdata_o = WIDTH'(ctrl_q);
      REG_STAT: begin
        rdata_o[ST_NEMPTY] = nempty;
        rdata_o[ST_FULL]   = full;
        rdata_o[ST_OVF]    = ovf_q;
        rdata_o[ST_OBF]    = obf_q;
        rdata_o[ST_INTR]   = intr_o;
      end
`ifdef PIO_EDGE_IRQ_EN
      REG_IMASK: rdata_o = imask_q;
      REG_IPEND: rdata_o = ipend_q;
`endif
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/pio_hs_n.sv
// pio_hs_n: NPORTS strobed-handshake parallel ports on one register bus.
// Bus decode, registered read data, access acknowledge and the irq OR.
// Define PIO_EDGE_IRQ_EN to enable per-bit change interrupts (IMASK/IPEND).
module pio_hs_n
  import pio_pkg::*;
#(
  parameter int NPORTS     = 2,
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cs_i,
  input  logic                      we_i,
  input  logic                      rd_i,
  input  logic [$clog2(NPORTS)+2:0] adr_i,
  input  logic [WIDTH-1:0]          dat_i,
  output logic [WIDTH-1:0]          dat_o,
  output logic                      ack_o,
  input  logic [NPORTS*WIDTH-1:0]   pin_i,
  output logic [NPORTS*WIDTH-1:0]   pin_o,
  output logic [NPORTS*WIDTH-1:0]   pin_oe,
  input  logic [NPORTS-1:0]         stb_ni,
  input  logic [NPORTS-1:0]         ack_ni,
  output logic [NPORTS-1:0]         obf_no,
  output logic                      irq_o
);

  localparam int AW  = $clog2(NPORTS) + 3;
  localparam int PIW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic             ack1_q, rdq_q, irq_q;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [PIW-1:0]   port_idx;
  logic [NPORTS-1:0] sel, intr;
  logic [WIDTH-1:0] port_rdata [NPORTS];
  logic             rd_first;

  if (NPORTS > 1) begin : g_idx
    assign port_idx = adr_i[AW-1:3];
  end else begin : g_idx1
    assign port_idx = '0;
  end

  // Side effects of a read only happen on its first cycle.
  assign rd_first = cs_i && rd_i && !rdq_q;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign sel[p] = (port_idx == PIW'(p));

    pio_port #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_port (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .wr_i    (cs_i && we_i && sel[p]),
      .rd_i    (rd_first && sel[p]),
      .reg_i   (adr_i[2:0]),
      .wdata_i (dat_i),
      .rdata_o (port_rdata[p]),
      .pin_i   (pin_i[p*WIDTH +: WIDTH]),
      .pin_o   (pin_o[p*WIDTH +: WIDTH]),
      .pin_oe  (pin_oe[p*WIDTH +: WIDTH]),
      .stb_ni  (stb_ni[p]),
      .ack_ni  (ack_ni[p]),
      .obf_no  (obf_no[p]),
      .intr_o  (intr[p])
    );
  end

  // Read data select; unmatched port index returns zero.
  always_comb begin
    dat_d = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (sel[p]) dat_d = port_rdata[p];
    end
  end

  // Bus-side registers: ack delay, read-first tracking, read data, irq.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack1_q <= 1'b0;
      rdq_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      ack1_q <= cs_i;
      rdq_q  <= cs_i && rd_i;
      irq_q  <= |intr;
      if (!cs_i)     dat_q <= '0;
      else if (rd_i) dat_q <= dat_d;
    end
  end

  assign ack_o = cs_i && (we_i || ack1_q);
  assign dat_o = dat_q;
  assign irq_o = irq_q;

endmodule
